// File: rtl/two_way_stream_demux.sv
// Registered 1-to-2 stream demultiplexer. Each accepted word is routed by sel to
// one of two independent 2-deep FIFOs, and each port keeps a delivery counter.

module two_way_stream_demux_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             valid,
   output logic             full,
   output logic [WIDTH-1:0] dout
);

   logic [1:0]       occ;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;

   // head always holds the oldest word; tail is used only at occupancy 2.
   // Popping the last word leaves head untouched so the port keeps driving the
   // last value while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               if (occ == 2'd2) head <= tail;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= din;
               end else begin
                  head <= tail;
                  tail <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign valid = (occ != 2'd0);
   assign full  = (occ == 2'd2);
   assign dout  = head;

endmodule

module two_way_stream_demux #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             sel,
   output logic             in_ready,
   output logic             true_valid,
   output logic [WIDTH-1:0] true_data,
   input  logic             true_ready,
   output logic             false_valid,
   output logic [WIDTH-1:0] false_data,
   input  logic             false_ready,
   output logic [CNT_W-1:0] true_cnt,
   output logic [CNT_W-1:0] false_cnt
);

   logic trueFull;
   logic falseFull;
   logic accept;
   logic truePush;
   logic falsePush;
   logic truePop;
   logic falsePop;

   // Readiness depends only on registered occupancy and sel, never on the
   // consumers' ready inputs, so no combinational path crosses the block.
   assign in_ready  = sel ? !trueFull : !falseFull;
   assign accept    = in_valid && in_ready;
   assign truePush  = accept && sel;
   assign falsePush = accept && !sel;
   assign truePop   = true_valid && true_ready;
   assign falsePop  = false_valid && false_ready;

   two_way_stream_demux_fifo #(.WIDTH(WIDTH)) trueFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (truePush),
      .din   (in_data),
      .pop   (truePop),
      .valid (true_valid),
      .full  (trueFull),
      .dout  (true_data)
   );

   two_way_stream_demux_fifo #(.WIDTH(WIDTH)) falseFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (falsePush),
      .din   (in_data),
      .pop   (falsePop),
      .valid (false_valid),
      .full  (falseFull),
      .dout  (false_data)
   );

   // Delivery counters wrap silently at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         true_cnt  <= '0;
         false_cnt <= '0;
      end else begin
         if (truePop)  true_cnt  <= true_cnt + 1'b1;
         if (falsePop) false_cnt <= false_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_two_way_stream_demux.sv
// Scoreboard bench for two_way_stream_demux: stimulus queues expected words per
// port, a negedge monitor pops and compares deliveries, readiness and counters.

module tb_two_way_stream_demux;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             sel = 1'b0;
   logic             in_ready;
   logic             true_valid;
   logic [WIDTH-1:0] true_data;
   logic             true_ready = 1'b0;
   logic             false_valid;
   logic [WIDTH-1:0] false_data;
   logic             false_ready = 1'b0;
   logic [CNT_W-1:0] true_cnt;
   logic [CNT_W-1:0] false_cnt;

   int checkCount = 0;
   int passCount  = 0;

   logic [WIDTH-1:0] trueQ[$];
   logic [WIDTH-1:0] falseQ[$];
   int trueDelivered  = 0;
   int falseDelivered = 0;
   int truePend  = 0;
   int falsePend = 0;

   always #5 clk = ~clk;

   two_way_stream_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .sel         (sel),
      .in_ready    (in_ready),
      .true_valid  (true_valid),
      .true_data   (true_data),
      .true_ready  (true_ready),
      .false_valid (false_valid),
      .false_data  (false_data),
      .false_ready (false_ready),
      .true_cnt    (true_cnt),
      .false_cnt   (false_cnt)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: a word is in the DUT once its accept edge has passed, so words
   // pushed earlier in this same cycle (pending) are not yet visible.
   always @(negedge clk) begin
      if (rst) begin
         trueQ.delete();
         falseQ.delete();
         trueDelivered  = 0;
         falseDelivered = 0;
      end else begin
         checkOutput("true_cnt", 64'(true_cnt), 64'(trueDelivered % (1 << CNT_W)));
         checkOutput("false_cnt", 64'(false_cnt), 64'(falseDelivered % (1 << CNT_W)));
         checkOutput("true_valid", 64'(true_valid), 64'((trueQ.size() - truePend) != 0));
         checkOutput("false_valid", 64'(false_valid), 64'((falseQ.size() - falsePend) != 0));
         if (true_valid && true_ready && trueQ.size() > 0) begin
            checkOutput("true_data", 64'(true_data), 64'(trueQ[0]));
            void'(trueQ.pop_front());
            trueDelivered++;
         end
         if (false_valid && false_ready && falseQ.size() > 0) begin
            checkOutput("false_data", 64'(false_data), 64'(falseQ[0]));
            void'(falseQ.pop_front());
            falseDelivered++;
         end
      end
   end

   // One cycle of stimulus; accepted reports whether the model expects the
   // word to be taken at the coming edge.
   task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d,
                                input logic tr, input logic fr, output logic accepted);
      logic expReady;
      @(posedge clk);
      #1;
      truePend    = 0;
      falsePend   = 0;
      in_valid    = v;
      sel         = s;
      in_data     = d;
      true_ready  = tr;
      false_ready = fr;
      #1;
      expReady = s ? (trueQ.size() < 2) : (falseQ.size() < 2);
      checkOutput("in_ready", 64'(in_ready), 64'(expReady));
      accepted = v && expReady;
      if (accepted) begin
         if (s) begin
            trueQ.push_back(d);
            truePend = 1;
         end else begin
            falseQ.push_back(d);
            falsePend = 1;
         end
      end
   endtask

   task automatic doReset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         truePend  = 0;
         falsePend = 0;
         rst      = 1'b1;
         in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      logic acc;
      int budget = 0;
      while ((trueQ.size() > 0 || falseQ.size() > 0) && budget < 50) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
         budget++;
      end
      @(negedge clk);
      checkOutput("drain_left", 64'(trueQ.size() + falseQ.size()), 64'd0);
   endtask

   initial begin
      logic acc;
      logic [WIDTH-1:0] holdHead;

      // Reset then idle
      doReset(2);
      @(negedge clk);
      checkOutput("rst_true_valid", 64'(true_valid), 64'd0);
      checkOutput("rst_false_valid", 64'(false_valid), 64'd0);
      checkOutput("rst_true_data", 64'(true_data), 64'd0);
      checkOutput("rst_false_data", 64'(false_data), 64'd0);
      checkOutput("rst_true_cnt", 64'(true_cnt), 64'd0);
      checkOutput("rst_false_cnt", 64'(false_cnt), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

      // Streaming on TRUE
      applyStimulus(1'b1, 1'b1, 32'h11, 1'b1, 1'b1, acc);
      applyStimulus(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, acc);
      applyStimulus(1'b1, 1'b1, 32'h33, 1'b1, 1'b1, acc);
      drain();
      checkOutput("stream_true_cnt", 64'(true_cnt), 64'd3);

      // Backpressure on FALSE
      applyStimulus(1'b1, 1'b0, 32'hA, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 1'b0, 32'hB, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 1'b0, 32'hC, 1'b1, 1'b0, acc);
      checkOutput("bp_third_refused", 64'(acc), 64'd0);
      acc = 1'b0;
      for (int i = 0; i < 5 && !acc; i++)
         applyStimulus(1'b1, 1'b0, 32'hC, 1'b1, 1'b1, acc);
      checkOutput("bp_third_taken", 64'(acc), 64'd1);
      drain();
      checkOutput("bp_false_cnt", 64'(false_cnt), 64'd3);

      // Independence: TRUE full and stalled, FALSE still accepts
      applyStimulus(1'b1, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 1'b1, 32'hDEAD0002, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, acc);
      checkOutput("indep_accept", 64'(acc), 64'd1);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
      @(negedge clk);
      checkOutput("indep_false_data", 64'(false_data), 64'h55);
      checkOutput("indep_true_head", 64'(true_data), 64'hDEAD0001);

      // Mid-operation reset with both FIFOs full
      applyStimulus(1'b1, 1'b0, 32'h66, 1'b0, 1'b0, acc);
      doReset(1);
      @(negedge clk);
      checkOutput("mid_rst_true_valid", 64'(true_valid), 64'd0);
      checkOutput("mid_rst_false_valid", 64'(false_valid), 64'd0);
      checkOutput("mid_rst_true_cnt", 64'(true_cnt), 64'd0);
      applyStimulus(1'b1, 1'b1, 32'hF00D, 1'b1, 1'b1, acc);
      applyStimulus(1'b1, 1'b0, 32'hBEEF, 1'b1, 1'b1, acc);
      drain();

      // Counter wrap: 17 deliveries on TRUE with a 4-bit counter
      doReset(1);
      for (int i = 0; i < 17; i++)
         applyStimulus(1'b1, 1'b1, WIDTH'(i + 100), 1'b1, 1'b0, acc);
      drain();
      checkOutput("wrap_true_cnt", 64'(true_cnt), 64'd1);

      // Randomised traffic with varying consumer readiness
      for (int i = 0; i < 400; i++) begin
         holdHead = $urandom;
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), holdHead,
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), acc);
      end
      drain();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
